// File: rtl/cgra_im_loader_pkg.sv
// Shared CGRA definitions: loader FSM encoding and host header field layout.
package cgra_im_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ID_DATA = 3'd1,
        S_IMM_LO  = 3'd2,
        S_IMM_HI  = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    // Header beat layout: bank=[7:0], start address=[15:8], count=[31:16]
    localparam int HDR_BANK_LSB = 0;
    localparam int HDR_BANK_W   = 8;
    localparam int HDR_ADDR_LSB = 8;
    localparam int HDR_ADDR_W   = 8;
    localparam int HDR_CNT_LSB  = 16;
    localparam int HDR_CNT_W    = 16;

endpackage

// File: rtl/cgra_im_loader.sv
// Host-stream loader for the CGRA instruction memories. A header beat selects
// a bank, start address and word count; data beats follow and are written to
// the selected bank one word per beat (ID banks) or one word per two beats
// (IMM banks, low word first).
module cgra_im_loader
    import cgra_im_loader_pkg::*;
#(
    parameter int D_WIDTH           = 32,
    parameter int I_WIDTH           = 12,
    parameter int I_IMM_WIDTH       = 33,
    parameter int IM_MEM_ADDR_WIDTH = 8,
    parameter int NUM_ID            = 6,
    parameter int NUM_IMM           = 3
) (
    input  logic                         iClk,
    input  logic                         iReset_n,
    input  logic [D_WIDTH-1:0]           iHost_Data,
    input  logic                         iHost_Valid,
    output logic                         oHost_Ready,
    input  logic                         iAbort,
    output logic [NUM_ID+NUM_IMM-1:0]    oIM_WriteEnable,
    output logic [IM_MEM_ADDR_WIDTH-1:0] oIM_WriteAddress,
    output logic [I_WIDTH-1:0]           oIM_WriteData,
    output logic [I_IMM_WIDTH-1:0]       oIM_WriteData_IMM,
    output logic                         oBusy,
    output logic                         oDone,
    output logic                         oError
);

    localparam int NB = NUM_ID + NUM_IMM;
    localparam int AW = IM_MEM_ADDR_WIDTH;
    localparam int CW = AW + 1;              // must hold a full-memory count
    localparam int HW = I_IMM_WIDTH - D_WIDTH;

    state_e                 state_q, state_d;
    logic [HDR_BANK_W-1:0]  bank_q, bank_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [D_WIDTH-1:0]     lo_q, lo_d;
    logic [NB-1:0]          we_q, we_d;
    logic [AW-1:0]          wr_addr_q, wr_addr_d;
    logic [I_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic [I_IMM_WIDTH-1:0] wr_imm_q, wr_imm_d;
    logic                   err_q, err_d;

    logic [HDR_BANK_W-1:0]  hdr_bank;
    logic [HDR_ADDR_W-1:0]  hdr_addr;
    logic [HDR_CNT_W-1:0]   hdr_cnt;
    logic                   hdr_bad, hdr_is_imm;
    logic [NB-1:0]          sel_oh;
    logic                   beat, last;

    assign oHost_Ready       = (state_q != S_DONE);
    assign oBusy             = (state_q == S_ID_DATA) || (state_q == S_IMM_LO) ||
                               (state_q == S_IMM_HI);
    assign oDone             = (state_q == S_DONE);
    assign oError            = err_q;
    assign oIM_WriteEnable   = we_q;
    assign oIM_WriteAddress  = wr_addr_q;
    assign oIM_WriteData     = wr_data_q;
    assign oIM_WriteData_IMM = wr_imm_q;

    assign beat = iHost_Valid && oHost_Ready;
    assign last = (cnt_q == CW'(1));

    // Header decode: field extraction and legality of bank/count
    always_comb begin
        hdr_bank   = iHost_Data[HDR_BANK_LSB +: HDR_BANK_W];
        hdr_addr   = iHost_Data[HDR_ADDR_LSB +: HDR_ADDR_W];
        hdr_cnt    = iHost_Data[HDR_CNT_LSB  +: HDR_CNT_W];
        hdr_bad    = (32'(hdr_bank) >= NB) ||
                     (32'(hdr_cnt) > (32'd1 << AW));
        hdr_is_imm = (32'(hdr_bank) >= NUM_ID);
    end

    // One-hot strobe for the latched bank
    always_comb begin
        sel_oh = '0;
        for (int b = 0; b < NB; b++) begin
            sel_oh[b] = (32'(bank_q) == b);
        end
    end

    // Next-state and write generation; abort overrides any beat this cycle
    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        we_d      = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_imm_d  = wr_imm_q;
        err_d     = 1'b0;
        if (iAbort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (beat) begin
                        if (hdr_bad) begin
                            err_d = 1'b1;
                        end else if (hdr_cnt == '0) begin
                            state_d = S_DONE;
                        end else begin
                            bank_d  = hdr_bank;
                            addr_d  = AW'(hdr_addr);
                            cnt_d   = CW'(hdr_cnt);
                            state_d = hdr_is_imm ? S_IMM_LO : S_ID_DATA;
                        end
                    end
                end
                S_ID_DATA: begin
                    if (beat) begin
                        we_d      = sel_oh;
                        wr_addr_d = addr_q;
                        wr_data_d = iHost_Data[I_WIDTH-1:0];
                        addr_d    = addr_q + AW'(1);
                        cnt_d     = cnt_q - CW'(1);
                        if (last) state_d = S_DONE;
                    end
                end
                S_IMM_LO: begin
                    if (beat) begin
                        lo_d    = iHost_Data;
                        state_d = S_IMM_HI;
                    end
                end
                S_IMM_HI: begin
                    if (beat) begin
                        we_d      = sel_oh;
                        wr_addr_d = addr_q;
                        wr_imm_d  = {iHost_Data[HW-1:0], lo_q};
                        addr_d    = addr_q + AW'(1);
                        cnt_d     = cnt_q - CW'(1);
                        state_d   = last ? S_DONE : S_IMM_LO;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, load context and registered write port
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q   <= S_IDLE;
            bank_q    <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            lo_q      <= '0;
            we_q      <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_imm_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            lo_q      <= lo_d;
            we_q      <= we_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_imm_q  <= wr_imm_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_cgra_im_loader.sv
// Directed bench for cgra_im_loader: header decode, ID/IMM loads, address
// wrap, error/zero-count headers, abort and mid-load reset.
module tb_cgra_im_loader;

    localparam int NB = 9;

    logic        iClk = 1'b0;
    logic        iReset_n;
    logic [31:0] iHost_Data;
    logic        iHost_Valid;
    logic        oHost_Ready;
    logic        iAbort;
    logic [8:0]  oIM_WriteEnable;
    logic [7:0]  oIM_WriteAddress;
    logic [11:0] oIM_WriteData;
    logic [32:0] oIM_WriteData_IMM;
    logic        oBusy, oDone, oError;

    cgra_im_loader dut (
        .iClk              (iClk),
        .iReset_n          (iReset_n),
        .iHost_Data        (iHost_Data),
        .iHost_Valid       (iHost_Valid),
        .oHost_Ready       (oHost_Ready),
        .iAbort            (iAbort),
        .oIM_WriteEnable   (oIM_WriteEnable),
        .oIM_WriteAddress  (oIM_WriteAddress),
        .oIM_WriteData     (oIM_WriteData),
        .oIM_WriteData_IMM (oIM_WriteData_IMM),
        .oBusy             (oBusy),
        .oDone             (oDone),
        .oError            (oError)
    );

    always #5 iClk = ~iClk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write / pulse recorder, sampled away from the active edge
    int          wr_n = 0, done_n = 0, err_n = 0;
    logic [8:0]  w_en   [64];
    logic [7:0]  w_addr [64];
    logic [11:0] w_data [64];
    logic [32:0] w_imm  [64];

    always @(negedge iClk) begin
        if (iReset_n) begin
            if (|oIM_WriteEnable && wr_n < 64) begin
                w_en[wr_n]   = oIM_WriteEnable;
                w_addr[wr_n] = oIM_WriteAddress;
                w_data[wr_n] = oIM_WriteData;
                w_imm[wr_n]  = oIM_WriteData_IMM;
                wr_n++;
            end
            if (oDone)  done_n++;
            if (oError) err_n++;
        end
    end

    // Present one beat; returns right after the edge that accepts it
    task automatic send(input logic [31:0] d, input logic ab = 1'b0);
        int n = 0;
        @(negedge iClk);
        iHost_Data  = d;
        iHost_Valid = 1'b1;
        iAbort      = ab;
        #1;
        while (!oHost_Ready && n < 20) begin
            @(negedge iClk);
            #1;
            n++;
        end
        if (!oHost_Ready) chk("ready_timeout", 64'(oHost_Ready), 64'd1);
        @(posedge iClk);
    endtask

    task automatic idle(input int n);
        @(negedge iClk);
        iHost_Valid = 1'b0;
        iAbort      = 1'b0;
        iHost_Data  = '0;
        repeat (n) @(negedge iClk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_we"},   64'(oIM_WriteEnable),   64'd0);
        chk({tag, "_addr"}, 64'(oIM_WriteAddress),  64'd0);
        chk({tag, "_data"}, 64'(oIM_WriteData),     64'd0);
        chk({tag, "_imm"},  64'(oIM_WriteData_IMM), 64'd0);
        chk({tag, "_busy"}, 64'(oBusy),             64'd0);
        chk({tag, "_done"}, 64'(oDone),             64'd0);
        chk({tag, "_err"},  64'(oError),            64'd0);
        chk({tag, "_rdy"},  64'(oHost_Ready),       64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int b, d0, e0;
        iReset_n    = 1'b0;
        iHost_Valid = 1'b0;
        iHost_Data  = '0;
        iAbort      = 1'b0;
        repeat (2) @(negedge iClk);
        #1;
        chk_outputs_zero("rst");
        @(negedge iClk);
        iReset_n = 1'b1;

        // ID load, back-to-back beats
        b = wr_n; d0 = done_n;
        send(32'h0003_1001);
        send(32'h0000_000A);
        send(32'h0000_000B);
        send(32'h0000_000C);
        idle(3);
        chk("id_nwr", 64'(wr_n - b), 64'd3);
        chk("id_en0", 64'(w_en[b]), 64'h002);
        chk("id_a0", 64'(w_addr[b]), 64'h10);
        chk("id_d0", 64'(w_data[b]), 64'hA);
        chk("id_a1", 64'(w_addr[b+1]), 64'h11);
        chk("id_d1", 64'(w_data[b+1]), 64'hB);
        chk("id_en2", 64'(w_en[b+2]), 64'h002);
        chk("id_a2", 64'(w_addr[b+2]), 64'h12);
        chk("id_d2", 64'(w_data[b+2]), 64'hC);
        chk("id_done", 64'(done_n - d0), 64'd1);

        // IMM load, bank NUM_ID
        b = wr_n; d0 = done_n;
        send(32'h0001_0006);
        send(32'hDEAD_BEEF);
        send(32'h0000_0001);
        idle(3);
        chk("imm_nwr", 64'(wr_n - b), 64'd1);
        chk("imm_en", 64'(w_en[b]), 64'h040);
        chk("imm_a", 64'(w_addr[b]), 64'h00);
        chk("imm_d", 64'(w_imm[b]), 64'h1_DEAD_BEEF);
        chk("imm_done", 64'(done_n - d0), 64'd1);

        // Address wrap
        b = wr_n;
        send(32'h0003_FE00);
        send(32'h0000_0001);
        send(32'h0000_0002);
        send(32'h0000_0003);
        idle(3);
        chk("wrap_nwr", 64'(wr_n - b), 64'd3);
        chk("wrap_a0", 64'(w_addr[b]), 64'hFE);
        chk("wrap_a1", 64'(w_addr[b+1]), 64'hFF);
        chk("wrap_a2", 64'(w_addr[b+2]), 64'h00);
        chk("wrap_en", 64'(w_en[b+2]), 64'h001);

        // count=0: done, no error, no write
        b = wr_n; d0 = done_n; e0 = err_n;
        send(32'h0000_0003);
        idle(3);
        chk("c0_done", 64'(done_n - d0), 64'd1);
        chk("c0_err", 64'(err_n - e0), 64'd0);
        chk("c0_nwr", 64'(wr_n - b), 64'd0);

        // count=257 is illegal
        b = wr_n; e0 = err_n;
        send(32'h0101_0000);
        idle(3);
        chk("cbig_err", 64'(err_n - e0), 64'd1);
        chk("cbig_nwr", 64'(wr_n - b), 64'd0);
        chk("cbig_busy", 64'(oBusy), 64'd0);

        // Bad bank, then a valid header; upper data bits ignored
        b = wr_n; e0 = err_n; d0 = done_n;
        send(32'h0001_0009);
        send(32'h0001_0502);
        send(32'hABCD_E077);
        idle(3);
        chk("bank9_err", 64'(err_n - e0), 64'd1);
        chk("bank9_nwr", 64'(wr_n - b), 64'd1);
        chk("bank9_en", 64'(w_en[b]), 64'h004);
        chk("bank9_a", 64'(w_addr[b]), 64'h05);
        chk("bank9_d", 64'(w_data[b]), 64'h077);
        chk("bank9_done", 64'(done_n - d0), 64'd1);

        // Abort on second data beat
        b = wr_n; d0 = done_n;
        send(32'h0003_2000);
        send(32'h0000_0011);
        send(32'h0000_0022, 1'b1);
        idle(3);
        chk("abort_nwr", 64'(wr_n - b), 64'd1);
        chk("abort_d", 64'(w_data[b]), 64'h011);
        chk("abort_a", 64'(w_addr[b]), 64'h20);
        chk("abort_busy", 64'(oBusy), 64'd0);
        chk("abort_rdy", 64'(oHost_Ready), 64'd1);
        chk("abort_done", 64'(done_n - d0), 64'd0);
        b = wr_n;
        send(32'h0001_3001);
        send(32'h0000_0005);
        idle(3);
        chk("post_abort_nwr", 64'(wr_n - b), 64'd1);
        chk("post_abort_en", 64'(w_en[b]), 64'h002);
        chk("post_abort_a", 64'(w_addr[b]), 64'h30);

        // Reset between IMM_LO and IMM_HI
        b = wr_n;
        send(32'h0001_0007);
        send(32'h1234_5678);
        @(negedge iClk);
        iHost_Valid = 1'b0;
        iReset_n    = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        @(negedge iClk);
        iReset_n = 1'b1;
        idle(2);
        chk("midrst_nwr", 64'(wr_n - b), 64'd0);
        send(32'h0001_0308);
        send(32'hCAFE_F00D);
        send(32'h0000_0000);
        idle(3);
        chk("rstload_nwr", 64'(wr_n - b), 64'd1);
        chk("rstload_en", 64'(w_en[b]), 64'h100);
        chk("rstload_a", 64'(w_addr[b]), 64'h03);
        chk("rstload_d", 64'(w_imm[b]), 64'h0_CAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cgra_im_loader.md
CGRA_IM_LOADER -- requirements
Module: cgra_im_loader

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, meaning host stream word width.
REQ-002 SHALL have parameter I_WIDTH, default 12, meaning decoded-unit instruction width.
REQ-003 SHALL have parameter I_IMM_WIDTH, default 33, meaning immediate-unit instruction width; legal range D_WIDTH+1 to 2*D_WIDTH.
REQ-004 SHALL have parameter IM_MEM_ADDR_WIDTH, default 8, meaning instruction memory address width.
REQ-005 SHALL have parameters NUM_ID, default 6, and NUM_IMM, default 3, meaning bank counts; banks 0..NUM_ID-1 are ID, NUM_ID..NUM_ID+NUM_IMM-1 are IMM.
REQ-006 SHALL have port iClk, input, 1, the single clock; every flop is rising-edge.
REQ-007 SHALL have port iReset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port iHost_Data, input, D_WIDTH, host stream word.
REQ-009 SHALL have port iHost_Valid, input, 1, and port oHost_Ready, output, 1, for the valid/ready host handshake.
REQ-010 SHALL have port iAbort, input, 1, synchronous load abort.
REQ-011 SHALL have port oIM_WriteEnable, output, NUM_ID+NUM_IMM, one-hot bank write strobe.
REQ-012 SHALL have port oIM_WriteAddress, output, IM_MEM_ADDR_WIDTH, shared write address.
REQ-013 SHALL have port oIM_WriteData, output, I_WIDTH, and port oIM_WriteData_IMM, output, I_IMM_WIDTH, for shared write data.
REQ-014 SHALL have port oBusy, output, 1, high while a load is in progress.
REQ-015 SHALL have port oDone, output, 1, and port oError, output, 1, each a one-cycle status pulse.

Function
REQ-016 SHALL complete a beat transfer only on a cycle where iHost_Valid and oHost_Ready are both 1.
REQ-017 SHALL decode a header beat as bank=[7:0], start address=[15:8], count=[31:16].
REQ-018 SHALL implement FSM states IDLE, ID_DATA, IMM_LO, IMM_HI and DONE.
REQ-019 SHALL, in IDLE, accept a header and move to ID_DATA for an ID bank or IMM_LO for an IMM bank, with count in 1..2^IM_MEM_ADDR_WIDTH.
REQ-020 SHALL, on a header with count=0, move to DONE without writing and without pulsing oError.
REQ-021 SHALL, on a header with bank>=NUM_ID+NUM_IMM or count>2^IM_MEM_ADDR_WIDTH, pulse oError for one cycle, stay in IDLE and write nothing.
REQ-022 SHALL, in ID_DATA, write each accepted beat's [I_WIDTH-1:0] to the selected bank.
REQ-023 SHALL, in IMM_LO, latch the low D_WIDTH bits and move to IMM_HI.
REQ-024 SHALL, in IMM_HI, supply the remaining I_IMM_WIDTH-D_WIDTH bits from [I_IMM_WIDTH-D_WIDTH-1:0], issue the write, then return to IMM_LO or, after the last word, go to DONE.
REQ-025 SHALL register every write output, so the write appears exactly one cycle after the completing beat.
REQ-026 SHALL hold oIM_WriteEnable all-zero on every cycle that carries no write.
REQ-027 SHALL increment the write address after each write, wrapping modulo 2^IM_MEM_ADDR_WIDTH.
REQ-028 SHALL move from ID_DATA to DONE when the last word is accepted.
REQ-029 SHALL hold DONE for one cycle with oHost_Ready=0 and oDone=1, then return to IDLE.
REQ-030 SHALL drive oHost_Ready=1 in every state except DONE.
REQ-031 SHALL drive oBusy=1 in ID_DATA, IMM_LO and IMM_HI.
REQ-032 SHALL, on iAbort=1 in any state, go to IDLE on the next edge, suppress that cycle's write, and give iAbort priority over a simultaneous beat.
REQ-033 SHALL not pulse oDone after an abort.
REQ-034 SHALL insert no bubbles and lose no data under back-to-back valid beats.
REQ-035 SHALL ignore all iHost_Data bits that a state does not use.

Reset
REQ-036 SHALL, while iReset_n=0, force the state to IDLE and clear the latched low word and word counter.
REQ-037 SHALL, while iReset_n=0, force oIM_WriteEnable, oIM_WriteAddress, oIM_WriteData, oIM_WriteData_IMM, oBusy, oDone and oError to 0, and drive oHost_Ready=1.
REQ-038 SHALL, on reset mid-load, discard the partial load with no further writes, and resume header decode on the first edge after reset deasserts.

Structure
REQ-039 SHALL take the FSM state encoding and header field offsets from the shared CGRA package.
REQ-040 SHALL be one module with no sub-modules; the header decoder is combinational logic inside it.

Verification
REQ-041 SHALL check: header bank=1, addr=0x10, count=3, then 0xA,0xB,0xC back-to-back -> writes 0xA@0x10, 0xB@0x11, 0xC@0x12 on enable bit1, then oDone one cycle.
REQ-042 SHALL check: header bank=NUM_ID, addr=0, count=1, then beats 0xDEADBEEF and 0x1 -> one write of 0x1DEADBEEF to bank NUM_ID at address 0.
REQ-043 SHALL check: header addr=0xFE, count=3 -> writes at addresses 0xFE, 0xFF, 0x00.
REQ-044 SHALL check: header bank=9 -> oError pulses once, no enable is ever set, and the next valid header loads correctly.
REQ-045 SHALL check: iAbort asserted with the 2nd data beat -> only the 1st word is written, FSM is in IDLE, oDone stays 0.
REQ-046 SHALL check: iReset_n pulsed low between IMM_LO and IMM_HI -> no write, all outputs 0, the next header is decoded normally.
